// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams coefficient words from a valid/ready source into
// a FIR filter's indexed coefficient write port, one tap per strobe.
// Optional feature macro: COEFF_SYMMETRIC_EN. When it is defined, only the
// first half of a symmetric impulse response is streamed. Each word is
// written to tap j and then to tap NTAPS-1-j. An odd-length centre tap is
// written once.
// All outputs are registers. reset is synchronous and active high.
module fir_coeff_loader #(
  parameter int NTAPS = 41,
  parameter int DW    = 16,
  parameter int SELW  = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            s_valid,
  input  logic [DW-1:0]   s_data,
  output logic            s_ready,
  output logic            coeff_update,
  output logic [SELW-1:0] coeff_sel,
  output logic [DW-1:0]   new_coeff,
  output logic            busy,
  output logic            done
);

  // Elaboration-time guard: every tap index must be representable on coeff_sel
  generate
    if ((2 ** SELW) < NTAPS) begin : g_selw_check
      $error("fir_coeff_loader: 2**SELW must be >= NTAPS");
    end
  endgenerate

`ifdef COEFF_SYMMETRIC_EN
  localparam int NWORDS = (NTAPS + 1) / 2;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    MIRROR = 2'd2,
    DONE   = 2'd3
  } state_t;
`else
  localparam int NWORDS = NTAPS;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  // Counter is one bit wider than the select so that it can hold the word quota itself
  localparam logic [SELW:0] QUOTA   = NWORDS[SELW:0];
  localparam logic [SELW:0] CNT_ONE = {{SELW{1'b0}}, 1'b1};

  state_t        state;
  logic [SELW:0] cnt;
  logic [SELW:0] cnt_next;

`ifdef COEFF_SYMMETRIC_EN
  localparam int            LAST_TAP_I = NTAPS - 1;
  localparam logic [SELW:0] LAST_TAP   = LAST_TAP_I[SELW:0];

  logic [SELW:0]   mirror_idx;
  logic            has_mirror;
  logic [SELW-1:0] mirror_sel;

  // Partner tap of the word being accepted; the odd-length centre tap has none
  always_comb begin
    mirror_idx = LAST_TAP - cnt;
    has_mirror = (mirror_idx != cnt);
  end
`endif

  // Word counter value after the current word has been accepted
  always_comb begin
    cnt_next = cnt + CNT_ONE;
  end

  // Sequencer: state, word counter and every registered output
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      s_ready      <= 1'b0;
      coeff_update <= 1'b0;
      coeff_sel    <= '0;
      new_coeff    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef COEFF_SYMMETRIC_EN
      mirror_sel   <= '0;
`endif
    end else begin
      // Strobes default low; coeff_sel/new_coeff keep their last written value
      coeff_update <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          // abort wins over a coincident start
          if (start && !abort) begin
            state   <= LOAD;
            cnt     <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            // A word offered in this cycle is dropped along with the sequence
            state   <= IDLE;
            cnt     <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end else if (cnt == QUOTA) begin
            // Final write has just been presented; flag completion
            state   <= DONE;
            s_ready <= 1'b0;
            done    <= 1'b1;
          end else if (s_valid && s_ready) begin
            coeff_update <= 1'b1;
            coeff_sel    <= cnt[SELW-1:0];
            new_coeff    <= s_data;
            cnt          <= cnt_next;
`ifdef COEFF_SYMMETRIC_EN
            if (has_mirror) begin
              state      <= MIRROR;
              s_ready    <= 1'b0;
              mirror_sel <= mirror_idx[SELW-1:0];
            end else begin
              state      <= LOAD;
              s_ready    <= (cnt_next != QUOTA);
            end
`else
            // Ready drops while the last word is written, so no extra word slips in
            s_ready <= (cnt_next != QUOTA);
`endif
          end else begin
            state <= LOAD;
          end
        end
`ifdef COEFF_SYMMETRIC_EN
        MIRROR: begin
          if (abort) begin
            // Suppress the pending mirrored write
            state   <= IDLE;
            cnt     <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end else begin
            coeff_update <= 1'b1;
            coeff_sel    <= mirror_sel;
            state        <= LOAD;
            s_ready      <= (cnt != QUOTA);
          end
        end
`endif
        DONE: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
